// File: rtl/powlib_sfifo_pkg.sv
// Shared helpers for the powlib single-clock FIFO: pointer/count width sizing.
package powlib_sfifo_pkg;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int powlib_clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/powlib_wrapcntr.sv
// Modulo-(MAX+1) pointer counter: advances on adv, wraps MAX->0, synchronous clear.
module powlib_wrapcntr #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] cntr
);

  localparam logic [W-1:0] LAST = W'(MAX);

  always_ff @(posedge clk) begin
    if (clr) begin
      cntr <= '0;
    end else if (adv) begin
      cntr <= (cntr == LAST) ? '0 : cntr + W'(1);
    end
  end

endmodule

// File: rtl/powlib_sfifo.sv
// Single-clock valid/ready FIFO, D words of W bits, first-word-fall-through by default.
// Define POWLIB_SFIFO_OREG_EN to register rddata/rdvld (capacity D+1, 2-cycle empty latency).
module powlib_sfifo
  import powlib_sfifo_pkg::*;
#(
  parameter int    W    = 16,
  parameter int    D    = 8,
  parameter int    WIDX = powlib_clogb2(D),
  parameter int    WCNT = powlib_clogb2(D + 2),
  parameter int    AFT  = D - 1,
  parameter int    AET  = 1,
  parameter int    EDBG = 0,
  parameter string ID   = "SFIFO"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    wrdata,
  input  logic            wrvld,
  output logic            wrrdy,
  output logic [W-1:0]    rddata,
  output logic            rdvld,
  input  logic            rdrdy,
  output logic [WCNT-1:0] cnt,
  output logic            afull,
  output logic            aempty
);

  localparam logic [WCNT-1:0] RAM_FULL = WCNT'(D);

  logic [W-1:0]    mem [D];
  logic [WIDX-1:0] wrptr;
  logic [WIDX-1:0] rdptr;
  logic [WCNT-1:0] ram_cnt;
  logic            wr_acc;
  logic            ram_rd;
  logic            out_acc;

  if (EDBG != 0) begin : g_dbg
    $info("%s: debug build", ID);
  end

  assign wrrdy  = !rst && (ram_cnt != RAM_FULL);
  assign wr_acc = wrvld && wrrdy;

`ifdef POWLIB_SFIFO_OREG_EN
  logic         oreg_vld;
  logic [W-1:0] oreg_dat;

  // The output slot is part of cnt, so the RAM holds everything else.
  assign ram_cnt = cnt - WCNT'(oreg_vld);
  assign ram_rd  = !rst && (ram_cnt != '0) && (!oreg_vld || rdrdy);
  assign out_acc = !rst && oreg_vld && rdrdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      oreg_vld <= 1'b0;
    end else if (ram_rd) begin
      oreg_vld <= 1'b1;
    end else if (out_acc) begin
      oreg_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_rd) begin
      oreg_dat <= mem[rdptr];
    end
  end

  assign rdvld  = oreg_vld;
  assign rddata = oreg_dat;
`else
  assign ram_cnt = cnt;
  assign rdvld   = (cnt != '0);
  assign rddata  = mem[rdptr];
  assign ram_rd  = !rst && rdvld && rdrdy;
  assign out_acc = ram_rd;
`endif

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wrptr] <= wrdata;
    end
  end

  powlib_wrapcntr #(.W(WIDX), .MAX(D - 1)) u_wrptr (
    .clk  (clk),
    .clr  (rst),
    .adv  (wr_acc),
    .cntr (wrptr)
  );

  powlib_wrapcntr #(.W(WIDX), .MAX(D - 1)) u_rdptr (
    .clk  (clk),
    .clr  (rst),
    .adv  (ram_rd),
    .cntr (rdptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr_acc && !out_acc) begin
      cnt <= cnt + WCNT'(1);
    end else if (!wr_acc && out_acc) begin
      cnt <= cnt - WCNT'(1);
    end
  end

  assign afull  = int'(cnt) >= AFT;
  assign aempty = int'(cnt) <= AET;

endmodule

// File: tb/tb_powlib_sfifo.sv
// Scoreboard bench for powlib_sfifo: D=4 instance for directed cases, D=5 for wrap/stall traffic.
module tb_powlib_sfifo;

`ifdef POWLIB_SFIFO_OREG_EN
  localparam int CAP5 = 6;
`else
  localparam int CAP5 = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_wrdata, a_rddata, b_wrdata, b_rddata;
  logic       a_wrvld, a_wrrdy, a_rdvld, a_rdrdy, a_afull, a_aempty;
  logic       b_wrvld, b_wrrdy, b_rdvld, b_rdrdy, b_afull, b_aempty;
  logic [2:0] a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  powlib_sfifo #(.W(8), .D(4)) u_a (
    .clk(clk), .rst(rst), .wrdata(a_wrdata), .wrvld(a_wrvld), .wrrdy(a_wrrdy),
    .rddata(a_rddata), .rdvld(a_rdvld), .rdrdy(a_rdrdy), .cnt(a_cnt),
    .afull(a_afull), .aempty(a_aempty)
  );

  powlib_sfifo #(.W(8), .D(5)) u_b (
    .clk(clk), .rst(rst), .wrdata(b_wrdata), .wrvld(b_wrvld), .wrrdy(b_wrrdy),
    .rddata(b_rddata), .rdvld(b_rdvld), .rdrdy(b_rdrdy), .cnt(b_cnt),
    .afull(b_afull), .aempty(b_aempty)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_wrvld = 1'b1; a_wrdata = 8'h77; a_rdrdy = 1'b0;
    b_wrvld = 1'b1; b_wrdata = 8'h66; b_rdrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({a_wrrdy, a_rdvld, a_cnt, a_aempty} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: wrrdy/rdvld/cnt/aempty=%b/%b/%0d/%b want 0/0/0/1",
                 i, a_wrrdy, a_rdvld, a_cnt, a_aempty);
      end
    end
    rst = 1'b0; a_wrvld = 1'b0; b_wrvld = 1'b0;
    step();
    checks++;
    if ({a_wrrdy, a_rdvld, a_cnt, a_aempty, a_afull} !== {1'b1, 1'b0, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: wrrdy/rdvld/cnt/aempty/afull=%b/%b/%0d/%b/%b want 1/0/0/1/0",
               a_wrrdy, a_rdvld, a_cnt, a_aempty, a_afull);
    end
    checks++;
    if ({b_wrrdy, b_rdvld, b_cnt} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_release_b: wrrdy/rdvld/cnt=%b/%b/%0d want 1/0/0", b_wrrdy, b_rdvld, b_cnt);
    end
  endtask

  // Drains qa.size() words from instance A with rdrdy held high.
  task automatic drain_a(input string tag);
    logic [7:0] exp;
    int n;
    n = qa.size();
    a_rdrdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (a_rdvld !== 1'b1) begin
        errors++;
        $display("FAIL %s_rdvld word%0d: got %b want 1", tag, i, a_rdvld);
      end else begin
        exp = qa.pop_front();
        checks++;
        if (a_rddata !== exp) begin
          errors++;
          $display("FAIL %s_data word%0d: got %h want %h", tag, i, a_rddata, exp);
        end
      end
      step();
    end
    a_rdrdy = 1'b0;
    checks++;
    if ({a_rdvld, a_cnt} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL %s_empty: rdvld/cnt=%b/%0d want 0/0", tag, a_rdvld, a_cnt);
    end
  endtask

`ifndef POWLIB_SFIFO_OREG_EN
  task automatic test_fill_drain();
    a_rdrdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_wrvld = 1'b1; a_wrdata = 8'((i + 1) * 8'h11);
      if (a_wrvld && a_wrrdy) qa.push_back(a_wrdata);
      step();
      checks++;
      if ({a_cnt, a_afull, a_aempty} !== {3'(i + 1), (i + 1) >= 3, (i + 1) <= 1}) begin
        errors++;
        $display("FAIL fill_flags w%0d: cnt/afull/aempty=%0d/%b/%b want %0d/%b/%b",
                 i, a_cnt, a_afull, a_aempty, i + 1, (i + 1) >= 3, (i + 1) <= 1);
      end
    end
    a_wrvld = 1'b0;
    checks++;
    if (a_wrrdy !== 1'b0) begin
      errors++;
      $display("FAIL fill_full_wrrdy: got %b want 0", a_wrrdy);
    end
    drain_a("fill_drain");
  endtask

  task automatic test_full_simul();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      a_wrvld = 1'b1; a_wrdata = 8'(8'hA1 + i);
      if (a_wrrdy) qa.push_back(a_wrdata);
      step();
    end
    a_wrvld = 1'b1; a_wrdata = 8'h55; a_rdrdy = 1'b1;
    checks++;
    if ({a_wrrdy, a_rdvld} !== 2'b01) begin
      errors++;
      $display("FAIL full_simul_hs: wrrdy/rdvld=%b/%b want 0/1", a_wrrdy, a_rdvld);
    end
    exp = qa.pop_front();
    checks++;
    if (a_rddata !== exp) begin
      errors++;
      $display("FAIL full_simul_data: got %h want %h", a_rddata, exp);
    end
    if (a_wrrdy) qa.push_back(a_wrdata);
    step();
    a_rdrdy = 1'b0;
    checks++;
    if (a_cnt !== 3'd3) begin
      errors++;
      $display("FAIL full_simul_cnt: got %0d want 3", a_cnt);
    end
    checks++;
    if (a_wrrdy !== 1'b1) begin
      errors++;
      $display("FAIL full_simul_retry_wrrdy: got %b want 1", a_wrrdy);
    end
    if (a_wrrdy) qa.push_back(a_wrdata);
    step();
    a_wrvld = 1'b0;
    checks++;
    if (a_cnt !== 3'd4) begin
      errors++;
      $display("FAIL full_simul_refill_cnt: got %0d want 4", a_cnt);
    end
    drain_a("full_simul");
  endtask

  task automatic test_empty_simul();
    a_wrvld = 1'b1; a_wrdata = 8'hA5; a_rdrdy = 1'b1;
    checks++;
    if (a_rdvld !== 1'b0) begin
      errors++;
      $display("FAIL empty_simul_rdvld: got %b want 0", a_rdvld);
    end
    if (a_wrrdy) qa.push_back(a_wrdata);
    step();
    a_wrvld = 1'b0; a_rdrdy = 1'b0;
    checks++;
    if ({a_cnt, a_rdvld, a_rddata} !== {3'd1, 1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL empty_simul_next: cnt/rdvld/rddata=%0d/%b/%h want 1/1/a5", a_cnt, a_rdvld, a_rddata);
    end
    drain_a("empty_simul");
  endtask
`else
  task automatic test_oreg_latency();
    a_wrvld = 1'b1; a_wrdata = 8'h01; a_rdrdy = 1'b0;
    if (a_wrrdy) qa.push_back(a_wrdata);
    step();
    a_wrvld = 1'b0;
    checks++;
    if ({a_rdvld, a_cnt} !== {1'b0, 3'd1}) begin
      errors++;
      $display("FAIL oreg_lat_cyc1: rdvld/cnt=%b/%0d want 0/1", a_rdvld, a_cnt);
    end
    step();
    checks++;
    if ({a_rdvld, a_rddata} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL oreg_lat_cyc2: rdvld/rddata=%b/%h want 1/01", a_rdvld, a_rddata);
    end
    drain_a("oreg_lat");
  endtask

  task automatic test_oreg_capacity();
    int acc;
    acc = 0;
    a_rdrdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_wrvld = 1'b1; a_wrdata = 8'(8'h10 + i);
      if (a_wrrdy) begin
        qa.push_back(a_wrdata);
        acc++;
      end
      step();
    end
    a_wrvld = 1'b0;
    checks++;
    if (acc != 5 || a_cnt !== 3'd5 || a_wrrdy !== 1'b0) begin
      errors++;
      $display("FAIL oreg_capacity: accepted/cnt/wrrdy=%0d/%0d/%b want 5/5/0", acc, a_cnt, a_wrrdy);
    end
  endtask

  task automatic test_oreg_back_to_back();
    drain_a("oreg_b2b");
  endtask
`endif

  task automatic test_wrap();
    logic [7:0] exp;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 600) begin
      b_wrvld  = (sent < 20) && ($urandom_range(0, 3) != 0);
      b_wrdata = 8'(sent * 37 + 5);
      b_rdrdy  = (cyc < 8) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (b_rdvld && b_rdrdy) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL wrap_underflow cyc%0d: rdvld=1 with nothing outstanding", cyc);
        end else begin
          exp = qb.pop_front();
          if (b_rddata !== exp) begin
            errors++;
            $display("FAIL wrap_data word%0d: got %h want %h", got, b_rddata, exp);
          end
        end
        got++;
      end
      if (b_wrvld && b_wrrdy) begin
        qb.push_back(b_wrdata);
        sent++;
      end
      step();
      cyc++;
      checks++;
      if (b_cnt !== 3'(qb.size()) || int'(b_cnt) > CAP5) begin
        errors++;
        $display("FAIL wrap_cnt cyc%0d: got %0d want %0d (max %0d)", cyc, b_cnt, qb.size(), CAP5);
      end
    end
    b_wrvld = 1'b0; b_rdrdy = 1'b0;
    checks++;
    if (got != 20) begin
      errors++;
      $display("FAIL wrap_timeout: read %0d words want 20", got);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_wrdata = '0; a_wrvld = 1'b0; a_rdrdy = 1'b0;
    b_wrdata = '0; b_wrvld = 1'b0; b_rdrdy = 1'b0;
    test_reset();
`ifndef POWLIB_SFIFO_OREG_EN
    test_fill_drain();
    test_full_simul();
    test_empty_simul();
`else
    test_oreg_latency();
    test_oreg_capacity();
    test_oreg_back_to_back();
`endif
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
